// File: rtl/mem_stage_responder.sv
// MEM-stage responder: turns pipeline load/store requests into pmem
// transactions, resolving LDI/STI pointer indirection internally.
module mem_stage_responder #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_read,
  input  logic                  req_write,
  input  logic [1:0]            req_byte_enable,
  input  logic                  req_indirect,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  stall,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [1:0]            pmem_byte_enable,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [DATA_WIDTH-1:0] pmem_wdata,
  input  logic [DATA_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    INDIRECT,
    DONE
  } state_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [1:0]            be;
    logic                  ind;
    logic                  wr;
  } req_t;

  localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~ADDR_WIDTH'(1);

  state_t                state_q, state_d;
  req_t                  req_q, req_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  assign resp_rdata = rdata_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      req_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    req_d            = req_q;
    rdata_d          = rdata_q;
    stall            = 1'b0;
    resp_valid       = 1'b0;
    pmem_read        = 1'b0;
    pmem_write       = 1'b0;
    pmem_byte_enable = 2'b11;
    pmem_address     = '0;
    pmem_wdata       = '0;
    unique case (state_q)
      IDLE: begin
        if (req_read || req_write) begin
          stall   = 1'b1;
          req_d   = '{addr:  req_addr,
                      wdata: req_wdata,
                      be:    req_byte_enable,
                      ind:   req_indirect,
                      wr:    req_write};
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        stall        = 1'b1;
        pmem_address = req_q.addr & WORD_MASK;
        // indirect requests always fetch the pointer first
        if (req_q.wr && !req_q.ind) begin
          pmem_write       = 1'b1;
          pmem_byte_enable = req_q.be;
          pmem_wdata       = req_q.wdata;
        end else begin
          pmem_read = 1'b1;
        end
        if (pmem_resp) begin
          if (req_q.ind) begin
            req_d.addr = ADDR_WIDTH'(pmem_rdata);
            state_d    = INDIRECT;
          end else begin
            if (!req_q.wr) rdata_d = pmem_rdata;
            state_d = DONE;
          end
        end
      end
      INDIRECT: begin
        stall        = 1'b1;
        pmem_address = req_q.addr & WORD_MASK;
        if (req_q.wr) begin
          pmem_write = 1'b1;
          pmem_wdata = req_q.wdata;
        end else begin
          pmem_read = 1'b1;
        end
        if (pmem_resp) begin
          if (!req_q.wr) rdata_d = pmem_rdata;
          state_d = DONE;
        end
      end
      DONE: begin
        resp_valid = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_stage_responder.sv
// Randomized self-checking bench for mem_stage_responder with a
// behavioural memory model acting as the pmem side.
module tb_mem_stage_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_read;
  logic        req_write;
  logic [1:0]  req_byte_enable;
  logic        req_indirect;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        stall;
  logic        resp_valid;
  logic [15:0] resp_rdata;
  logic        pmem_read;
  logic        pmem_write;
  logic [1:0]  pmem_byte_enable;
  logic [15:0] pmem_address;
  logic [15:0] pmem_wdata;
  logic [15:0] pmem_rdata;
  logic        pmem_resp;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] mem [logic [15:0]];
  logic [15:0] exp_rdata = 16'h0;

  mem_stage_responder dut (
    .clk              (clk),
    .reset            (reset),
    .req_read         (req_read),
    .req_write        (req_write),
    .req_byte_enable  (req_byte_enable),
    .req_indirect     (req_indirect),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .stall            (stall),
    .resp_valid       (resp_valid),
    .resp_rdata       (resp_rdata),
    .pmem_read        (pmem_read),
    .pmem_write       (pmem_write),
    .pmem_byte_enable (pmem_byte_enable),
    .pmem_address     (pmem_address),
    .pmem_wdata       (pmem_wdata),
    .pmem_rdata       (pmem_rdata),
    .pmem_resp        (pmem_resp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] mrd(input logic [15:0] a);
    if (!mem.exists(a)) mem[a] = 16'($urandom);
    return mem[a];
  endfunction

  task automatic access(input logic w, input logic [15:0] a,
                        input logic [1:0] be, input logic [15:0] wd,
                        input int lat, output logic [15:0] rd);
    logic [15:0] m;
    rd = w ? 16'h0 : mrd(a);
    for (int c = 0; c <= lat; c++) begin
      pmem_resp  = (c == lat);
      pmem_rdata = (c == lat && !w) ? rd : 16'($urandom);
      #1;
      chk("acc_stall", stall, 1);
      chk("acc_rd", pmem_read, !w);
      chk("acc_wr", pmem_write, w);
      chk("acc_addr", pmem_address, a);
      chk("acc_be", pmem_byte_enable, be);
      if (w) chk("acc_wdata", pmem_wdata, wd);
      chk("acc_rv", resp_valid, 0);
      chk("acc_rdata_hold", resp_rdata, exp_rdata);
      @(posedge clk); #1;
    end
    pmem_resp = 1'b0;
    if (w) begin
      m = mrd(a);
      if (be[0]) m[7:0] = wd[7:0];
      if (be[1]) m[15:8] = wd[15:8];
      mem[a] = m;
    end
  endtask

  task automatic run_req(input logic rd, input logic wr,
                         input logic [1:0] be, input logic ind,
                         input logic [15:0] a, input logic [15:0] wd,
                         input int lat0, input int lat1,
                         input logic hold);
    logic [15:0] ptr, r;
    @(posedge clk); #1;
    req_read        = rd;
    req_write       = wr;
    req_byte_enable = be;
    req_indirect    = ind;
    req_addr        = a;
    req_wdata       = wd;
    #1;
    chk("idle_stall", stall, 1);
    chk("idle_rd", pmem_read, 0);
    chk("idle_wr", pmem_write, 0);
    chk("idle_rv", resp_valid, 0);
    @(posedge clk); #1;
    if (ind) begin
      access(1'b0, a & 16'hFFFE, 2'b11, wd, lat0, ptr);
      access(wr, ptr & 16'hFFFE, 2'b11, wd, lat1, r);
    end else begin
      access(wr, a & 16'hFFFE, wr ? be : 2'b11, wd, lat0, r);
    end
    if (!wr) exp_rdata = r;
    if (!hold) begin
      req_read  = 1'b0;
      req_write = 1'b0;
    end
    pmem_resp  = 1'($urandom);
    pmem_rdata = 16'($urandom);
    #1;
    chk("done_rv", resp_valid, 1);
    chk("done_stall", stall, 0);
    chk("done_rdata", resp_rdata, exp_rdata);
    chk("done_rd", pmem_read, 0);
    chk("done_wr", pmem_write, 0);
    pmem_resp = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    pmem_resp  = 1'($urandom);
    pmem_rdata = 16'($urandom);
    #1;
    chk("quiet_stall", stall, 0);
    chk("quiet_rv", resp_valid, 0);
    chk("quiet_rd", pmem_read, 0);
    chk("quiet_wr", pmem_write, 0);
    chk("quiet_rdata", resp_rdata, exp_rdata);
    pmem_resp = 1'b0;
  endtask

  initial begin
    logic        rd, wr, ind;
    logic [1:0]  be;
    logic [15:0] a;
    reset           = 1'b1;
    req_read        = 1'b0;
    req_write       = 1'b0;
    req_byte_enable = 2'b11;
    req_indirect    = 1'b0;
    req_addr        = 16'h0;
    req_wdata       = 16'h0;
    pmem_rdata      = 16'h0;
    pmem_resp       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_stall", stall, 0);
    chk("rst_rv", resp_valid, 0);
    chk("rst_rd", pmem_read, 0);
    chk("rst_wr", pmem_write, 0);
    chk("rst_be", pmem_byte_enable, 2'b11);
    chk("rst_addr", pmem_address, 0);
    chk("rst_wdata", pmem_wdata, 0);
    chk("rst_rdata", resp_rdata, 0);
    reset = 1'b0;
    idle_cycle();

    mem[16'h1234] = 16'hBEEF;
    run_req(1, 0, 2'b11, 0, 16'h1235, 16'h0, 2, 0, 0);
    idle_cycle();
    run_req(0, 1, 2'b10, 0, 16'h2001, 16'hAB00, 0, 0, 0);
    idle_cycle();
    mem[16'h3000] = 16'h4002;
    mem[16'h4002] = 16'h1111;
    run_req(1, 0, 2'b11, 1, 16'h3000, 16'h0, 0, 0, 0);
    idle_cycle();
    mem[16'h3000] = 16'h6001;
    run_req(0, 1, 2'b11, 1, 16'h3000, 16'h5A5A, 0, 0, 0);
    idle_cycle();
    chk("sti_mem", mem[16'h6000], 16'h5A5A);

    @(posedge clk); #1;
    req_read = 1'b1;
    req_addr = 16'h7000;
    @(posedge clk); #1;
    req_read = 1'b0;
    #1;
    chk("pre_rst_rd", pmem_read, 1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    exp_rdata = 16'h0;
    chk("arst_rd", pmem_read, 0);
    chk("arst_wr", pmem_write, 0);
    chk("arst_stall", stall, 0);
    chk("arst_rdata", resp_rdata, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    pmem_resp = 1'b1;
    #1;
    chk("late_rv0", resp_valid, 0);
    @(posedge clk); #1;
    pmem_resp = 1'b0;
    #1;
    chk("late_rv1", resp_valid, 0);
    chk("late_stall", stall, 0);

    run_req(1, 1, 2'b01, 0, 16'h2100, 16'h1234, 1, 0, 1);
    run_req(1, 1, 2'b01, 0, 16'h2100, 16'h1234, 0, 0, 0);
    idle_cycle();

    for (int i = 0; i < 60; i++) begin
      rd  = 1'($urandom);
      wr  = rd ? 1'($urandom) : 1'b1;
      be  = 2'($urandom_range(1, 3));
      ind = ($urandom_range(0, 3) == 0);
      a   = 16'h0100 + 16'($urandom_range(0, 15));
      if (ind) begin
        void'(mrd(a & 16'hFFFE));
        mem[a & 16'hFFFE] = 16'h0100 + 16'($urandom_range(0, 15));
      end
      run_req(rd, wr, be, ind, a, 16'($urandom),
              $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
      if ($urandom_range(0, 1) == 1) idle_cycle();
    end
    for (int k = 0; k < 16; k += 2)
      run_req(1, 0, 2'b11, 0, 16'h0100 + 16'(k), 16'h0, 0, 0, 0);
    idle_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
